// File: rtl/reg_loader.sv
// reg_loader: streams bytes into consecutive bank registers and verifies each by read-back
module reg_loader #(
   parameter int NUM_REGS  = 4,
   parameter int ADDR_W    = 2,
   parameter int DATA_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              write_enable,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);
   typedef enum logic [2:0] {IDLE, WAIT, WRITE, VERIFY, DONE} state_t;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(NUM_REGS);
   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] latch;
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         ptr          <= BASE;
         latch        <= '0;
         in_ready     <= 1'b0;
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         rd_addr      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         count        <= '0;
      end else begin
         write_enable <= 1'b0;
         case (state)
            IDLE, DONE: if (start) begin
               state    <= WAIT;
               ptr      <= BASE;
               rd_addr  <= BASE;
               count    <= '0;
               err      <= 1'b0;
               done     <= 1'b0;
               busy     <= 1'b1;
               in_ready <= 1'b1;
            end
            WAIT: if (in_valid) begin
               latch        <= in_data;
               write_enable <= 1'b1;
               write_addr   <= ptr;
               write_data   <= in_data;
               in_ready     <= 1'b0;
               state        <= WRITE;
            end
            WRITE: state <= VERIFY;
            VERIFY: begin
               // rd_addr already points at ptr, so rd_data is this register's value
               if (rd_data != latch) err <= 1'b1;
               count <= count + 1'b1;
               if (count + 1'b1 == LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  ptr      <= ptr + 1'b1;
                  rd_addr  <= ptr + 1'b1;
                  in_ready <= 1'b1;
                  state    <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_reg_loader.sv
// tb_reg_loader: directed checks of reg_loader against behavioural register banks
module tb_reg_loader;
   logic       clk = 1'b0, reset = 1'b1;
   logic       start_a = 1'b0, in_valid_a = 1'b0, fault = 1'b0;
   logic [7:0] in_data_a = '0;
   logic       in_ready_a, we_a, busy_a, done_a, err_a;
   logic [1:0] wa_a, ra_a;
   logic [7:0] wd_a, rd_a;
   logic [2:0] count_a;
   logic       start_b = 1'b0, in_valid_b = 1'b0;
   logic [7:0] in_data_b = '0;
   logic       in_ready_b, we_b, busy_b, done_b, err_b;
   logic [1:0] wa_b, ra_b;
   logic [7:0] wd_b, rd_b;
   logic [2:0] count_b;
   logic [7:0] bank_a [4];
   logic [7:0] bank_b [4];
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   reg_loader dut_a (
      .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid_a), .in_data(in_data_a),
      .in_ready(in_ready_a), .write_enable(we_a), .write_addr(wa_a), .write_data(wd_a),
      .rd_addr(ra_a), .rd_data(rd_a), .busy(busy_a), .done(done_a), .err(err_a), .count(count_a));
   reg_loader #(.NUM_REGS(2), .BASE_ADDR(3)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
      .in_ready(in_ready_b), .write_enable(we_b), .write_addr(wa_b), .write_data(wd_b),
      .rd_addr(ra_b), .rd_data(rd_b), .busy(busy_b), .done(done_b), .err(err_b), .count(count_b));
   // behavioural banks: write on strobe, combinational read; fault forces a bad read
   always @(posedge clk) begin
      if (we_a) bank_a[wa_a] <= wd_a;
      if (we_b) bank_b[wa_b] <= wd_b;
   end
   assign rd_a = fault ? 8'h00 : bank_a[ra_a];
   assign rd_b = bank_b[ra_b];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send_a(input logic [7:0] b, input logic [1:0] addr);
      in_valid_a = 1'b1;
      in_data_a  = b;
      tick();
      chk("send_we", {31'd0, we_a}, 1);
      chk("send_addr", {30'd0, wa_a}, {30'd0, addr});
      chk("send_data", {24'd0, wd_a}, {24'd0, b});
      in_valid_a = 1'b0;
      tick();
      chk("send_verify_we", {31'd0, we_a}, 0);
      tick();
   endtask
   initial begin
      for (int i = 0; i < 4; i++) begin
         bank_a[i] = '0;
         bank_b[i] = '0;
      end
      tick();
      tick();
      chk("rst_in_ready", {31'd0, in_ready_a}, 0);
      chk("rst_we", {31'd0, we_a}, 0);
      chk("rst_flags", {29'd0, busy_a, done_a, err_a}, 0);
      chk("rst_count", {29'd0, count_a}, 0);
      chk("rst_addrs", {26'd0, wa_a, ra_a, 2'd0}, 0);
      chk("rst_wdata", {24'd0, wd_a}, 0);
      reset = 1'b0;
      // basic stream, in_valid held high throughout
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("start_busy", {30'd0, busy_a, in_ready_a}, 3);
      in_valid_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data_a = 8'h11 * 8'(i + 1);
         tick();
         chk("str_we", {31'd0, we_a}, 1);
         chk("str_addr", {30'd0, wa_a}, i);
         chk("str_data", {24'd0, wd_a}, 32'h11 * (i + 1));
         tick();
         chk("str_we_off1", {31'd0, we_a}, 0);
         tick();
         chk("str_we_off2", {31'd0, we_a}, 0);
      end
      in_valid_a = 1'b0;
      chk("str_done", {29'd0, done_a, busy_a, err_a}, 4);
      chk("str_count", {29'd0, count_a}, 4);
      chk("str_bank", {bank_a[3], bank_a[2], bank_a[1], bank_a[0]}, 32'h44332211);
      // source stall in WAIT
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("restart_count", {29'd0, count_a}, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_ready", {31'd0, in_ready_a}, 1);
         chk("stall_we", {31'd0, we_a}, 0);
      end
      send_a(8'hA5, 2'd0);
      chk("stall_count", {29'd0, count_a}, 1);
      // reset in the cycle that would otherwise accept the 2nd byte
      reset = 1'b1;
      in_valid_a = 1'b1;
      in_data_a = 8'h77;
      tick();
      chk("abort_we", {31'd0, we_a}, 0);
      chk("abort_flags", {29'd0, busy_a, done_a, in_ready_a}, 0);
      chk("abort_count", {29'd0, count_a}, 0);
      reset = 1'b0;
      in_valid_a = 1'b0;
      tick();
      chk("abort_we_after", {31'd0, we_a}, 0);
      chk("abort_bank", {16'd0, bank_a[1], bank_a[0]}, 32'h22A5);
      // verify fault on the first byte, ignored start mid-run, restart from DONE
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      in_valid_a = 1'b1;
      in_data_a = 8'h5A;
      tick();
      chk("flt_we", {31'd0, we_a}, 1);
      tick();
      in_valid_a = 1'b0;
      fault = 1'b1;
      tick();
      fault = 1'b0;
      chk("flt_err", {31'd0, err_a}, 1);
      chk("flt_count", {29'd0, count_a}, 1);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("busy_start_count", {29'd0, count_a}, 1);
      chk("busy_start_err", {30'd0, err_a, in_ready_a}, 3);
      send_a(8'h01, 2'd1);
      send_a(8'h02, 2'd2);
      send_a(8'h03, 2'd3);
      chk("flt_done", {29'd0, done_a, busy_a, err_a}, 5);
      chk("flt_done_count", {29'd0, count_a}, 4);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("done_restart", {29'd0, done_a, busy_a, err_a}, 2);
      chk("done_restart_count", {29'd0, count_a}, 0);
      // wrapping base address on the second loader
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      in_valid_b = 1'b1;
      in_data_b = 8'hDE;
      tick();
      chk("wrap_we0", {31'd0, we_b}, 1);
      chk("wrap_wr0", {22'd0, wa_b, wd_b}, 32'h3DE);
      in_valid_b = 1'b0;
      tick();
      tick();
      in_valid_b = 1'b1;
      in_data_b = 8'hAD;
      tick();
      chk("wrap_wr1", {21'd0, we_b, wa_b, wd_b}, 32'h4AD);
      in_valid_b = 1'b0;
      tick();
      tick();
      chk("wrap_done", {29'd0, done_b, busy_b, err_b}, 4);
      chk("wrap_count", {29'd0, count_b}, 2);
      chk("wrap_bank", {16'd0, bank_b[3], bank_b[0]}, 32'hDEAD);
      in_valid_b = 1'b1;
      tick();
      chk("wrap_no_extra_we", {31'd0, we_b}, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/reg_loader.md
Name: reg_loader

Overview:
- Sequential write-side initiator for the 4x8-bit processor register bank.
- Accepts a stream of bytes over a valid/ready handshake and writes them into consecutive registers starting at BASE_ADDR, one register per byte.
- Reads each register back through one bank read port and flags mismatches.
- Used for boot-time register initialisation and by debug loaders; sits between the debug/boot byte source and the bank's write and read ports.

Parameters:
- NUM_REGS, 4, number of registers to load per run (1..2^ADDR_W).
- ADDR_W, 2, register address width.
- DATA_W, 8, register data width.
- BASE_ADDR, 0, first register address written.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load run; ignored unless in IDLE or DONE.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  DATA_W  byte to be written.
- in_ready  output  1  loader can accept a byte this cycle.
- write_enable  output  1  bank write strobe.
- write_addr  output  ADDR_W  bank write address.
- write_data  output  DATA_W  bank write data.
- rd_addr  output  ADDR_W  bank read-port address, used for verify.
- rd_data  input  DATA_W  bank read-port data, combinational from the bank.
- busy  output  1  run in progress (WAIT, WRITE or VERIFY).
- done  output  1  run complete; held until the next start or reset.
- err  output  1  sticky verify mismatch for the current run.
- count  output  ADDR_W+1  registers written and verified in the current run.

Behaviour:
- Reset (synchronous, active-high, dominates every other input):
  - state=IDLE, ptr=BASE_ADDR, latch=0.
  - in_ready=0, write_enable=0, write_addr=0, write_data=0, rd_addr=0.
  - busy=0, done=0, err=0, count=0.
- A reset in the middle of a run aborts it; no write_enable is issued on the reset cycle or after it.
- States:
  - IDLE: start=1 -> WAIT; ptr=BASE_ADDR, count=0, err=0, done=0.
  - WAIT: in_ready=1. On in_valid&&in_ready, latch in_data and go to WRITE. in_valid without ready has no effect.
  - WRITE: in_ready=0; write_enable=1 for exactly this cycle, write_addr=ptr, write_data=latch. The bank captures the value on this cycle's closing edge. Go to VERIFY.
  - VERIFY: rd_addr=ptr; compare rd_data with latch. On mismatch, err<=1 (sticky). count<=count+1. If count+1==NUM_REGS go to DONE; else ptr<=ptr+1 (modulo 2^ADDR_W, wraps) and go to WAIT.
  - DONE: done=1, busy=0. start=1 -> WAIT, with the same initialisation as from IDLE.
- Outside WRITE, write_enable=0 and write_addr/write_data hold their last values.
- rd_addr equals ptr in every state (it is 0 under reset).
- Throughput: 3 cycles per byte minimum (accept, WRITE, VERIFY). Back-to-back in_valid is accepted every third cycle.
- start while busy is ignored. start in the same cycle as reset: reset wins.
- Address wrap: with BASE_ADDR=2 and NUM_REGS=4, the write order is 2,3,0,1.
- The loader never writes more than NUM_REGS registers per run.
- Widths: count is ADDR_W+1 bits so that it can hold NUM_REGS. ptr is ADDR_W bits and wraps with no overflow flag.

Test Plan:
- Reset, then start; stream 0x11,0x22,0x33,0x44 with in_valid held high. Required response:
  - write_enable pulses at addresses 0,1,2,3 with those data values, exactly 3 cycles apart.
  - The bank ends holding 11/22/33/44.
  - done=1, count=4, err=0.
- Stall source: in_valid low for 5 cycles in WAIT -> in_ready stays 1, no write_enable, state unchanged; the byte sent afterwards (0xA5) is written at the correct address.
- BASE_ADDR=3, NUM_REGS=2: stream 0xDE,0xAD -> writes 0xDE to addr 3 and 0xAD to addr 0 (wrap); count=2, done=1.
- Verify fault: the bench forces rd_data=0x00 during VERIFY of byte 0x5A -> err=1 and stays 1 through DONE; a new start clears err to 0.
- Reset in the middle of a run, in the cycle before WRITE of the 2nd byte -> no write_enable occurs. The next cycle shows busy=0, done=0, count=0, in_ready=0.
- start pulsed during WAIT and again in DONE -> the first pulse has no effect; the second restarts the run (count=0, done=0, busy=1 next cycle).
